// File: rtl/vco_adc_seq.sv
// vco_adc_seq: conversion sequencer between the host register block and vco_adc.
// Define VCO_ADC_SEQ_AVG_EN to sum the captured samples into one result instead of streaming them.
module vco_adc_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int OSR_WIDTH  = 10,
    parameter int CNT_WIDTH  = 8,
    parameter int OFF_CYCLES = 4
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            start_i,
    input  logic                            stop_i,
    input  logic [OSR_WIDTH-1:0]            osr_i,
    input  logic [3:0]                      discard_i,
    input  logic [CNT_WIDTH-1:0]            count_i,
    output logic                            adc_enable_o,
    output logic [OSR_WIDTH-1:0]            adc_osr_o,
    input  logic [DATA_WIDTH-1:0]           adc_data_i,
    input  logic                            adc_valid_i,
    output logic [DATA_WIDTH+CNT_WIDTH-1:0] data_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            overrun_o
);

    localparam int OUT_W = DATA_WIDTH + CNT_WIDTH;
    localparam int OFF_W = $clog2(OFF_CYCLES + 1);
    localparam logic [OFF_W-1:0]     OFF_FULL = OFF_W'(OFF_CYCLES);
    localparam logic [OFF_W-1:0]     OFF_LAST = OFF_W'(OFF_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN_DISCARD,
        S_RUN_CAPTURE,
        S_DRAIN,
        S_OFF
    } state_t;

    state_t               state_q, state_d;
    logic [OSR_WIDTH-1:0] osr_q, osr_d;
    logic [3:0]           disc_q, disc_d;
    logic [CNT_WIDTH-1:0] target_q, target_d;
    logic [CNT_WIDTH-1:0] cap_q, cap_d;
    logic [OFF_W-1:0]     off_q, off_d;
    logic                 en_q, en_d;
    logic [OUT_W-1:0]     data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 overrun_q, overrun_d;
`ifdef VCO_ADC_SEQ_AVG_EN
    logic [OUT_W-1:0]     acc_q, acc_d;
`endif

    always_comb begin
        state_d   = state_q;
        osr_d     = osr_q;
        disc_d    = disc_q;
        target_d  = target_q;
        cap_d     = cap_q;
        off_d     = off_q;
        en_d      = en_q;
        data_d    = data_q;
        valid_d   = valid_q & ~ready_i;
        done_d    = 1'b0;
        overrun_d = overrun_q;
`ifdef VCO_ADC_SEQ_AVG_EN
        acc_d     = acc_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_i && off_q == OFF_FULL) begin
                    osr_d     = osr_i;
                    disc_d    = discard_i;
                    cap_d     = '0;
                    overrun_d = 1'b0;
                    en_d      = 1'b1;
`ifdef VCO_ADC_SEQ_AVG_EN
                    target_d  = (count_i == '0) ? CNT_WIDTH'(1) : count_i;
                    acc_d     = '0;
`else
                    target_d  = count_i;
`endif
                    state_d   = (discard_i == 4'd0) ? S_RUN_CAPTURE : S_RUN_DISCARD;
                end
            end
            S_RUN_DISCARD: begin
                if (adc_valid_i && disc_q != 4'd0) begin
                    disc_d = disc_q - 4'd1;
                    if (disc_q == 4'd1) state_d = S_RUN_CAPTURE;
                end
                if (stop_i) state_d = S_DRAIN;
            end
            S_RUN_CAPTURE: begin
                if (adc_valid_i) begin
                    if (cap_q != CNT_MAX) cap_d = cap_q + 1'b1;
`ifdef VCO_ADC_SEQ_AVG_EN
                    acc_d = acc_q + OUT_W'(adc_data_i);
`else
                    // A full register being read this cycle frees the slot for the new sample.
                    if (!valid_q || ready_i) begin
                        data_d  = OUT_W'(adc_data_i);
                        valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
`endif
                    if (target_q != '0 && cap_d == target_q) state_d = S_DRAIN;
                end
                if (stop_i) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!valid_q) begin
                    state_d = S_OFF;
                    off_d   = '0;
                end
            end
            S_OFF: begin
                if (off_q == OFF_LAST) begin
                    state_d = S_IDLE;
                    off_d   = OFF_FULL;
                    done_d  = 1'b1;
                end else begin
                    off_d = off_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Every path into DRAIN drops the ADC enable; in averaging mode it also publishes the sum.
        if (state_d == S_DRAIN && state_q != S_DRAIN) begin
            en_d = 1'b0;
`ifdef VCO_ADC_SEQ_AVG_EN
            data_d  = acc_d;
            valid_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            osr_q     <= '0;
            disc_q    <= '0;
            target_q  <= '0;
            cap_q     <= '0;
            off_q     <= OFF_FULL;
            en_q      <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef VCO_ADC_SEQ_AVG_EN
            acc_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            osr_q     <= osr_d;
            disc_q    <= disc_d;
            target_q  <= target_d;
            cap_q     <= cap_d;
            off_q     <= off_d;
            en_q      <= en_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
`ifdef VCO_ADC_SEQ_AVG_EN
            acc_q     <= acc_d;
`endif
        end
    end

    assign adc_enable_o = en_q;
    assign adc_osr_o    = osr_q;
    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = done_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_vco_adc_seq.sv
// tb_vco_adc_seq: directed and randomized runs of vco_adc_seq against expected sample lists and sums.
// Honours VCO_ADC_SEQ_AVG_EN the same way as the design.
module tb_vco_adc_seq;

    localparam int DW   = 32;
    localparam int OW   = 10;
    localparam int CW   = 8;
    localparam int OFFC = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start_i = 1'b0;
    logic          stop_i = 1'b0;
    logic [OW-1:0] osr_i = '0;
    logic [3:0]    discard_i = '0;
    logic [CW-1:0] count_i = '0;
    logic          adc_enable_o;
    logic [OW-1:0] adc_osr_o;
    logic [DW-1:0] adc_data_i = '0;
    logic          adc_valid_i = 1'b0;
    logic [DW+CW-1:0] data_o;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic          overrun_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    vco_adc_seq #(
        .DATA_WIDTH(DW),
        .OSR_WIDTH (OW),
        .CNT_WIDTH (CW),
        .OFF_CYCLES(OFFC)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .osr_i       (osr_i),
        .discard_i   (discard_i),
        .count_i     (count_i),
        .adc_enable_o(adc_enable_o),
        .adc_osr_o   (adc_osr_o),
        .adc_data_i  (adc_data_i),
        .adc_valid_i (adc_valid_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .overrun_o   (overrun_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [DW-1:0] d);
        adc_data_i  = d;
        adc_valid_i = 1'b1;
        tick();
        adc_valid_i = 1'b0;
    endtask

    task automatic start_run(input logic [OW-1:0] osr, input logic [3:0] disc, input logic [CW-1:0] cnt);
        osr_i     = osr;
        discard_i = disc;
        count_i   = cnt;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
        chk("start_busy", busy_o, 1);
        chk("start_enable", adc_enable_o, 1);
        chk("start_osr", adc_osr_o, osr);
        chk("start_overrun_clr", overrun_o, 0);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done_o !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        chk("done_seen", done_o, 1);
        chk("done_enable_low", adc_enable_o, 0);
        chk("done_idle", busy_o, 0);
        tick();
        chk("done_one_pulse", done_o, 0);
    endtask

    // mult=0 gives random samples, otherwise sample i is mult*(i+1); ready_i held high.
    task automatic run_stream(input logic [OW-1:0] osr, input int disc, input int cnt,
                              input int maxgap, input int mult);
        logic [DW-1:0]    d;
        logic [DW+CW-1:0] sum;
        int eff;
        int n;
        int gap;
        eff = cnt;
`ifdef VCO_ADC_SEQ_AVG_EN
        if (eff == 0) eff = 1;
`endif
        n   = disc + eff;
        sum = '0;
        ready_i = 1'b1;
        start_run(osr, 4'(disc), CW'(cnt));
        for (int i = 0; i < n; i++) begin
            d = (mult == 0) ? DW'($urandom) : DW'(mult * (i + 1));
            strobe(d);
            if (i >= disc) sum = sum + (DW+CW)'(d);
`ifdef VCO_ADC_SEQ_AVG_EN
            chk("avg_valid", valid_o, (i == n - 1) ? 1 : 0);
            if (i == n - 1) chk("avg_sum", data_o, sum);
`else
            chk("stream_valid", valid_o, (i >= disc) ? 1 : 0);
            if (i >= disc) chk("stream_data", data_o, (DW+CW)'(d));
`endif
            chk("run_enable", adc_enable_o, (i == n - 1) ? 0 : 1);
            chk("run_osr_hold", adc_osr_o, osr);
            if (i < n - 1) begin
                gap = $urandom_range(0, maxgap);
                for (int g = 0; g < gap; g++) begin
                    tick();
                    chk("gap_valid", valid_o, 0);
                end
            end
        end
        chk("stream_no_overrun", overrun_o, 0);
        wait_done();
    endtask

    initial begin
        logic [DW-1:0]    d0, d1, d2;
        logic [DW+CW-1:0] sum;
        logic [OW-1:0]    osr_a, osr_b;
        int low;
        bit seen_done;
        int ncap;

        // Reset state
        rstn = 1'b0;
        tick();
        tick();
        chk("rst_enable", adc_enable_o, 0);
        chk("rst_osr", adc_osr_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_overrun", overrun_o, 0);
        rstn = 1'b1;
        tick();

        // Directed: discard 2, capture 4 of 10..60
        run_stream(10'h0ff, 2, 4, 2, 10);

`ifdef VCO_ADC_SEQ_AVG_EN
        // Averaging: discard 1, sum of 2..5
        run_stream(10'h011, 1, 4, 1, 1);
`else
        // Host stalled: only the first of three samples survives
        ready_i = 1'b0;
        start_run(10'h005, 4'd0, 8'd3);
        d0 = DW'($urandom);
        d1 = DW'($urandom);
        d2 = DW'($urandom);
        strobe(d0);
        chk("stall_first_valid", valid_o, 1);
        chk("stall_first_data", data_o, (DW+CW)'(d0));
        chk("stall_no_overrun_yet", overrun_o, 0);
        tick();
        chk("stall_hold_valid", valid_o, 1);
        strobe(d1);
        chk("stall_overrun", overrun_o, 1);
        chk("stall_keep_data", data_o, (DW+CW)'(d0));
        strobe(d2);
        chk("stall_enable_low", adc_enable_o, 0);
        chk("stall_keep_data2", data_o, (DW+CW)'(d0));
        chk("stall_still_valid", valid_o, 1);
        ready_i = 1'b1;
        tick();
        chk("stall_consumed", valid_o, 0);
        wait_done();
        chk("overrun_sticky", overrun_o, 1);
`endif

        // Stop mid-run, off-time enforcement, osr held while busy
        ready_i = 1'b1;
        osr_a = 10'h2a5;
        osr_b = 10'h133;
`ifdef VCO_ADC_SEQ_AVG_EN
        ncap = 3;
        start_run(osr_a, 4'd1, 8'd10);
`else
        ncap = 5;
        start_run(osr_a, 4'd1, 8'd0);
`endif
        strobe(DW'($urandom));
        chk("stop_discarded", valid_o, 0);
        sum = '0;
        for (int i = 0; i < ncap; i++) begin
            d0 = DW'($urandom);
            strobe(d0);
            sum = sum + (DW+CW)'(d0);
`ifndef VCO_ADC_SEQ_AVG_EN
            chk("cont_valid", valid_o, 1);
            chk("cont_data", data_o, (DW+CW)'(d0));
`endif
            tick();
            chk("cont_enable", adc_enable_o, 1);
        end
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        chk("stop_enable_low", adc_enable_o, 0);
`ifdef VCO_ADC_SEQ_AVG_EN
        chk("stop_partial_valid", valid_o, 1);
        chk("stop_partial_sum", data_o, sum);
`else
        chk("stop_no_extra", valid_o, 0);
`endif
        osr_i   = osr_b;
        start_i = 1'b1;
        low       = 1;
        seen_done = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (adc_enable_o === 1'b1) break;
            low++;
            if (done_o === 1'b1) seen_done = 1'b1;
            chk("osr_held_busy", adc_osr_o, osr_a);
        end
        start_i = 1'b0;
        chk("restart_enable", adc_enable_o, 1);
        chk("off_low_time", (low >= OFFC) ? 1 : 0, 1);
        chk("done_before_restart", seen_done, 1);
        chk("osr_new_after_start", adc_osr_o, osr_b);
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        wait_done();

        // Reset mid-capture
        ready_i = 1'b0;
        start_run(10'h077, 4'd0, 8'd10);
        strobe(DW'($urandom));
        strobe(DW'($urandom));
        rstn = 1'b0;
        tick();
        chk("midrst_enable", adc_enable_o, 0);
        chk("midrst_valid", valid_o, 0);
        chk("midrst_data", data_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_overrun", overrun_o, 0);
        chk("midrst_osr", adc_osr_o, 0);
        rstn = 1'b1;
        for (int k = 0; k < OFFC + 3; k++) begin
            tick();
            chk("midrst_no_done", done_o, 0);
        end
        run_stream(10'h0ff, 2, 4, 1, 10);

        // Randomized runs
        for (int r = 0; r < 6; r++) begin
            run_stream(OW'($urandom_range(1, 1023)), $urandom_range(0, 3),
                       $urandom_range(1, 6), 2, 0);
        end

        // Full-scale count, back-to-back strobes
        run_stream(10'h3ff, 0, 255, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
